// File: rtl/plic_irq_gateway.sv
// rtl/plic_irq_gateway.sv - PLIC interrupt gateway with level/edge sources and claim/complete tracking
module plic_irq_gateway #(
    parameter int                     NUM_SOURCES = 32,
    parameter logic [NUM_SOURCES-1:0] EDGE_MASK   = NUM_SOURCES'(32'h0000_0006),
    parameter int                     CNT_WIDTH   = 4,
    localparam int                    ID_WIDTH    = $clog2(NUM_SOURCES)
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic [NUM_SOURCES-1:0] src_i,
    input  logic [NUM_SOURCES-1:0] enable_i,
    output logic [NUM_SOURCES-1:0] irq_o,
    output logic [NUM_SOURCES-1:0] inflight_o,
    input  logic                   claim_valid_i,
    input  logic [ID_WIDTH-1:0]    claim_id_i,
    input  logic                   complete_valid_i,
    input  logic [ID_WIDTH-1:0]    complete_id_i,
    output logic                   claim_err_o,
    output logic                   complete_err_o,
    output logic [NUM_SOURCES-1:0] overflow_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_INFLIGHT = 2'd2
    } state_e;

    // Line 0 is reserved: every trigger for it is masked so it never leaves IDLE.
    localparam logic [NUM_SOURCES-1:0] SRC_MASK = ~NUM_SOURCES'(1);
    localparam logic [NUM_SOURCES-1:0] EDGE_SRC = EDGE_MASK & SRC_MASK;
    localparam logic [CNT_WIDTH-1:0]   CNT_MAX  = {CNT_WIDTH{1'b1}};

    state_e               state_q [NUM_SOURCES];
    state_e               state_d [NUM_SOURCES];
    logic [CNT_WIDTH-1:0] cnt_q   [NUM_SOURCES];
    logic [CNT_WIDTH-1:0] cnt_d   [NUM_SOURCES];

    logic [NUM_SOURCES-1:0] src_q;
    logic [NUM_SOURCES-1:0] irq_q;
    logic [NUM_SOURCES-1:0] inflight_q;
    logic [NUM_SOURCES-1:0] overflow_q;
    logic [NUM_SOURCES-1:0] overflow_d;
    logic                   claim_err_q;
    logic                   claim_err_d;
    logic                   complete_err_q;
    logic                   complete_err_d;

    logic [NUM_SOURCES-1:0] active;
    logic [NUM_SOURCES-1:0] rise;
    logic [NUM_SOURCES-1:0] claim_sel;
    logic [NUM_SOURCES-1:0] complete_sel;
    logic [NUM_SOURCES-1:0] claim_ok;
    logic [NUM_SOURCES-1:0] complete_ok;

    assign active = src_i & enable_i & SRC_MASK;
    assign rise   = active & ~src_q;

    // Decode claim/complete IDs; out-of-range IDs match no source and are therefore illegal.
    always_comb begin
        claim_sel    = '0;
        complete_sel = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            claim_sel[i]    = claim_valid_i    && (claim_id_i    == ID_WIDTH'(i));
            complete_sel[i] = complete_valid_i && (complete_id_i == ID_WIDTH'(i));
        end
        claim_sel    = claim_sel & SRC_MASK;
        complete_sel = complete_sel & SRC_MASK;
    end

    // Legality is judged on start-of-cycle outputs, so a same-ID claim+complete fails the claim.
    assign claim_ok       = claim_sel & irq_q;
    assign complete_ok    = complete_sel & inflight_q;
    assign claim_err_d    = claim_valid_i & ~(|claim_ok);
    assign complete_err_d = complete_valid_i & ~(|complete_ok);

    // Per-source next state: edge sources track a saturating count, level sources follow the line.
    always_comb begin
        for (int i = 0; i < NUM_SOURCES; i++) begin
            state_d[i]    = state_q[i];
            cnt_d[i]      = cnt_q[i];
            overflow_d[i] = overflow_q[i];
            if (EDGE_SRC[i]) begin
                // A claim consuming one event cancels an edge arriving in the same cycle.
                if (rise[i] && !claim_ok[i]) begin
                    if (cnt_q[i] == CNT_MAX) begin
                        overflow_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                    end
                end else if (claim_ok[i] && !rise[i]) begin
                    cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
                end
                if (claim_ok[i]) begin
                    state_d[i] = ST_INFLIGHT;
                end else if ((state_q[i] == ST_INFLIGHT) && !complete_ok[i]) begin
                    state_d[i] = ST_INFLIGHT;
                end else begin
                    state_d[i] = (cnt_d[i] != '0) ? ST_PENDING : ST_IDLE;
                end
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (active[i]) begin
                            state_d[i] = ST_PENDING;
                        end
                    end
                    ST_PENDING: begin
                        // A dropped line does not clear pending; only a claim does.
                        if (claim_ok[i]) begin
                            state_d[i] = ST_INFLIGHT;
                        end
                    end
                    ST_INFLIGHT: begin
                        if (complete_ok[i]) begin
                            state_d[i] = active[i] ? ST_PENDING : ST_IDLE;
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // State, counters and registered outputs; reset overrides any same-cycle claim/complete.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_SOURCES; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            src_q          <= '0;
            irq_q          <= '0;
            inflight_q     <= '0;
            overflow_q     <= '0;
            claim_err_q    <= 1'b0;
            complete_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SOURCES; i++) begin
                state_q[i]    <= state_d[i];
                cnt_q[i]      <= cnt_d[i];
                irq_q[i]      <= (state_d[i] == ST_PENDING);
                inflight_q[i] <= (state_d[i] == ST_INFLIGHT);
            end
            src_q          <= src_i;
            overflow_q     <= overflow_d;
            claim_err_q    <= claim_err_d;
            complete_err_q <= complete_err_d;
        end
    end

    assign irq_o          = irq_q;
    assign inflight_o     = inflight_q;
    assign overflow_o     = overflow_q;
    assign claim_err_o    = claim_err_q;
    assign complete_err_o = complete_err_q;

endmodule

// File: tb/tb_plic_irq_gateway.sv
// tb/tb_plic_irq_gateway.sv - self-checking bench for plic_irq_gateway
module tb_plic_irq_gateway;

    localparam int            NS   = 32;
    localparam logic [NS-1:0] EM   = 32'h0000_0006;
    localparam int            CW   = 4;
    localparam int            CMAX = (1 << CW) - 1;
    localparam logic [31:0]   A    = 32'hFFFF_FFFF;

    logic          clock_i = 1'b0;
    logic          reset_i;
    logic [NS-1:0] src_i;
    logic [NS-1:0] enable_i;
    logic [NS-1:0] irq_o;
    logic [NS-1:0] inflight_o;
    logic          claim_valid_i;
    logic [4:0]    claim_id_i;
    logic          complete_valid_i;
    logic [4:0]    complete_id_i;
    logic          claim_err_o;
    logic          complete_err_o;
    logic [NS-1:0] overflow_o;

    always #5 clock_i = ~clock_i;

    plic_irq_gateway #(
        .NUM_SOURCES(NS),
        .EDGE_MASK  (EM),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .src_i           (src_i),
        .enable_i        (enable_i),
        .irq_o           (irq_o),
        .inflight_o      (inflight_o),
        .claim_valid_i   (claim_valid_i),
        .claim_id_i      (claim_id_i),
        .complete_valid_i(complete_valid_i),
        .complete_id_i   (complete_id_i),
        .claim_err_o     (claim_err_o),
        .complete_err_o  (complete_err_o),
        .overflow_o      (overflow_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending events per source as plain integers and flags.
    int m_cnt  [NS];
    bit m_pend [NS];
    bit m_inf  [NS];
    bit m_ovf  [NS];
    bit m_srcq [NS];
    bit m_cerr;
    bit m_perr;

    function automatic bit m_irq(int i);
        if (i == 0) return 1'b0;
        if (EM[i]) return (m_cnt[i] > 0) && !m_inf[i];
        return m_pend[i];
    endfunction

    function automatic void model_step(bit rst, logic [31:0] s, logic [31:0] e,
                                       bit cv, int ci, bit pv, int pi);
        bit cok, pok, here_c, here_p, act, rise;
        int n;
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                m_cnt[i] = 0; m_pend[i] = 0; m_inf[i] = 0; m_ovf[i] = 0; m_srcq[i] = 0;
            end
            m_cerr = 0;
            m_perr = 0;
            return;
        end
        cok = cv && ci != 0 && ci < NS && m_irq(ci);
        pok = pv && pi != 0 && pi < NS && m_inf[pi];
        for (int i = 1; i < NS; i++) begin
            here_c = cok && (ci == i);
            here_p = pok && (pi == i);
            act    = s[i] && e[i];
            rise   = act && !m_srcq[i];
            if (EM[i]) begin
                n = m_cnt[i] + (rise ? 1 : 0) - (here_c ? 1 : 0);
                if (n > CMAX) begin
                    n = CMAX;
                    m_ovf[i] = 1;
                end
                m_cnt[i] = n;
                if (here_c) m_inf[i] = 1;
                else if (here_p) m_inf[i] = 0;
            end else begin
                if (here_c) begin
                    m_pend[i] = 0;
                    m_inf[i]  = 1;
                end else if (here_p) begin
                    m_inf[i]  = 0;
                    m_pend[i] = act;
                end else if (!m_inf[i] && act) begin
                    m_pend[i] = 1;
                end
            end
        end
        for (int i = 0; i < NS; i++) m_srcq[i] = s[i];
        m_cerr = cv && !cok;
        m_perr = pv && !pok;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge, compare everything.
    task automatic cyc(bit rst, logic [31:0] s, logic [31:0] e, bit cv, int ci, bit pv, int pi);
        logic [31:0] xi, xf, xo;
        reset_i          = rst;
        src_i            = s;
        enable_i         = e;
        claim_valid_i    = cv;
        claim_id_i       = 5'(ci);
        complete_valid_i = pv;
        complete_id_i    = 5'(pi);
        model_step(rst, s, e, cv, ci, pv, pi);
        @(posedge clock_i);
        #1;
        for (int i = 0; i < NS; i++) begin
            xi[i] = m_irq(i);
            xf[i] = m_inf[i];
            xo[i] = m_ovf[i];
        end
        chk("model_irq", irq_o, xi);
        chk("model_inflight", inflight_o, xf);
        chk("model_overflow", overflow_o, xo);
        chk("model_claim_err", 32'(claim_err_o), 32'(m_cerr));
        chk("model_complete_err", 32'(complete_err_o), 32'(m_perr));
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] en;
        logic        cv;
        logic [4:0]  ci;
        logic        pv;
        logic [4:0]  pi;
        logic [31:0] x_irq;
        logic [31:0] x_inf;
        logic        x_cerr;
        logic        x_perr;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int pl[$];
        int il[$];
        logic [31:0] rs, re;
        bit rcv, rpv;
        int rci, rpi;

        tbl[0]  = '{32'h10, A, 0, 0, 0, 0, 32'h10, 32'h00, 0, 0};
        tbl[1]  = '{32'h10, A, 1, 4, 0, 0, 32'h00, 32'h10, 0, 0};
        tbl[2]  = '{32'h10, A, 0, 0, 1, 4, 32'h10, 32'h00, 0, 0};
        tbl[3]  = '{32'h00, A, 1, 4, 0, 0, 32'h00, 32'h10, 0, 0};
        tbl[4]  = '{32'h00, A, 0, 0, 1, 4, 32'h00, 32'h00, 0, 0};
        tbl[5]  = '{32'h00, A, 1, 0, 0, 0, 32'h00, 32'h00, 1, 0};
        tbl[6]  = '{32'h00, A, 1, 3, 0, 0, 32'h00, 32'h00, 1, 0};
        tbl[7]  = '{32'h00, A, 0, 0, 1, 5, 32'h00, 32'h00, 0, 1};
        tbl[8]  = '{32'h10, A, 0, 0, 0, 0, 32'h10, 32'h00, 0, 0};
        tbl[9]  = '{32'h10, A, 1, 4, 0, 0, 32'h00, 32'h10, 0, 0};
        tbl[10] = '{32'h10, A, 1, 4, 1, 4, 32'h10, 32'h00, 1, 0};
        tbl[11] = '{32'h10, A, 0, 0, 0, 0, 32'h10, 32'h00, 0, 0};
        tbl[12] = '{32'h18, A, 1, 4, 0, 0, 32'h08, 32'h10, 0, 0};
        tbl[13] = '{32'h18, A, 1, 3, 1, 4, 32'h10, 32'h08, 0, 0};
        tbl[14] = '{32'h00, A, 0, 0, 1, 3, 32'h10, 32'h00, 0, 0};
        tbl[15] = '{32'h20, ~32'h20, 0, 0, 0, 0, 32'h10, 32'h00, 0, 0};
        tbl[16] = '{32'h20, A, 0, 0, 0, 0, 32'h30, 32'h00, 0, 0};

        // Reset held two cycles with every line high, then released.
        cyc(1, A, A, 0, 0, 0, 0);
        cyc(1, A, A, 0, 0, 0, 0);
        chk("reset_irq", irq_o, 32'h0);
        chk("reset_inflight", inflight_o, 32'h0);
        chk("reset_overflow", overflow_o, 32'h0);
        chk("reset_errs", {30'b0, claim_err_o, complete_err_o}, 32'h0);
        cyc(0, A, A, 0, 0, 0, 0);
        chk("release_irq", irq_o, 32'hFFFF_FFFE);

        // Directed vector table from a clean reset.
        cyc(1, 0, A, 0, 0, 0, 0);
        for (int k = 0; k < 17; k++) begin
            cyc(0, tbl[k].src, tbl[k].en, tbl[k].cv, int'(tbl[k].ci), tbl[k].pv, int'(tbl[k].pi));
            chk($sformatf("tbl%0d_irq", k), irq_o, tbl[k].x_irq);
            chk($sformatf("tbl%0d_inflight", k), inflight_o, tbl[k].x_inf);
            chk($sformatf("tbl%0d_claim_err", k), 32'(claim_err_o), 32'(tbl[k].x_cerr));
            chk($sformatf("tbl%0d_complete_err", k), 32'(complete_err_o), 32'(tbl[k].x_perr));
        end

        // Edge source 2: three pulses, drained by three claim/complete pairs.
        for (int k = 0; k < 3; k++) begin
            cyc(0, 32'h4, A, 0, 0, 0, 0);
            cyc(0, 32'h0, A, 0, 0, 0, 0);
        end
        chk("edge3_irq2", 32'(irq_o[2]), 32'd1);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, A, 1, 2, 0, 0);
            chk("edge_claim_irq2", 32'(irq_o[2]), 32'd0);
            chk("edge_claim_inf2", 32'(inflight_o[2]), 32'd1);
            cyc(0, 0, A, 0, 0, 1, 2);
            chk("edge_complete_irq2", 32'(irq_o[2]), (k < 2) ? 32'd1 : 32'd0);
        end

        // Sixteen pulses into a 15-deep counter: one edge is lost.
        for (int k = 0; k < 16; k++) begin
            cyc(0, 32'h4, A, 0, 0, 0, 0);
            cyc(0, 32'h0, A, 0, 0, 0, 0);
        end
        chk("sat_overflow2", 32'(overflow_o[2]), 32'd1);
        for (int k = 0; k < 15; k++) begin
            cyc(0, 0, A, 1, 2, 0, 0);
            cyc(0, 0, A, 0, 0, 1, 2);
        end
        chk("drained_irq2", 32'(irq_o[2]), 32'd0);
        chk("drained_overflow2", 32'(overflow_o[2]), 32'd1);

        // Edge in the same cycle as a claim with cnt=1 leaves cnt at 1.
        cyc(0, 32'h4, A, 0, 0, 0, 0);
        cyc(0, 32'h0, A, 0, 0, 0, 0);
        cyc(0, 32'h4, A, 1, 2, 0, 0);
        chk("edgeclaim_inf2", 32'(inflight_o[2]), 32'd1);
        chk("edgeclaim_irq2", 32'(irq_o[2]), 32'd0);
        cyc(0, 32'h0, A, 0, 0, 1, 2);
        chk("edgeclaim_repend2", 32'(irq_o[2]), 32'd1);

        // Reset while a source is in flight, with a claim in the same cycle.
        cyc(0, 0, A, 1, 2, 0, 0);
        chk("pre_reset_inf2", 32'(inflight_o[2]), 32'd1);
        cyc(1, A, A, 1, 4, 1, 2);
        chk("midreset_irq", irq_o, 32'h0);
        chk("midreset_inflight", inflight_o, 32'h0);
        chk("midreset_overflow", overflow_o, 32'h0);
        chk("midreset_errs", {30'b0, claim_err_o, complete_err_o}, 32'h0);

        // Randomised traffic against the model.
        for (int t = 0; t < 2000; t++) begin
            pl.delete();
            il.delete();
            for (int i = 1; i < NS; i++) begin
                if (m_irq(i)) pl.push_back(i);
                if (m_inf[i]) il.push_back(i);
            end
            rs  = $urandom() & $urandom() & $urandom();
            re  = ($urandom_range(0, 9) == 0) ? $urandom() : A;
            rcv = ($urandom_range(0, 2) == 0);
            rpv = ($urandom_range(0, 2) == 0);
            if (pl.size() > 0 && $urandom_range(0, 3) != 0) rci = pl[$urandom_range(0, pl.size() - 1)];
            else rci = $urandom_range(0, 31);
            if (il.size() > 0 && $urandom_range(0, 3) != 0) rpi = il[$urandom_range(0, il.size() - 1)];
            else rpi = $urandom_range(0, 31);
            cyc($urandom_range(0, 299) == 0, rs, re, rcv, rci, rpv, rpi);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
